mux_rr_nxw: RTL
===============

Name: mux_rr_nxw

Overview:
- Parametrised N-input, W-bit registered selector with valid/ready handshake on every input and on the output.
- Picks one requesting input per cycle, either by round-robin arbitration or by an externally forced select, and captures it into a single-entry output register.
- Sits between multiple producers (e.g. writeback / bypass sources) and one shared consumer.
- Successor of the fixed 8:1 single-bit select mux: generalised in width and input count, with arbitration, flow control and pipelining.

Parameters:
- N, 8: number of inputs; legal range 2..16, need not be a power of two.
- W, 32: data width per input.
- SELW, $clog2(N): width of select/source-index fields; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  N  per-input request; bit i belongs to input i.
- in_data  input  N*W  packed data; input i occupies bits [i*W +: W].
- in_ready  output  N  per-input accept; at most one bit high per cycle.
- mode  input  1  0 = round-robin, 1 = forced select.
- force_sel  input  SELW  input index used when mode=1.
- out_valid  output  1  output register holds a valid entry.
- out_data  output  W  registered selected data.
- out_src  output  SELW  index of the input that supplied out_data.
- out_ready  input  1  consumer accepts the output entry this cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - Reset dominates any simultaneous transfer.
  - Mid-transfer reset discards the held entry.
  - in_ready is 0 while rst_n=0.
- Stage-free condition: space = ~out_valid | out_ready.
- Grant, combinational, at most one-hot:
  - mode=0: grant the first i with in_valid[i]=1, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
  - mode=1: grant force_sel iff force_sel<N and in_valid[force_sel]=1; force_sel>=N yields no grant.
  - No in_valid bits set: no grant.
- in_ready[i] = grant[i] & space & rst_n.
  - Depends combinationally on in_valid and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Accept (any in_ready bit high) at clk edge:
  - out_data <= in_data of the granted input; out_src <= granted index; out_valid <= 1.
  - ptr <= granted index + 1, wrapping N-1 -> 0. ptr updates in both modes.
- Drain only (out_valid & out_ready, no accept): out_valid <= 0; out_data and out_src hold their values.
- Simultaneous drain and accept: new entry replaces the old one in the same edge; out_valid stays 1. Sustains one transfer per cycle.
- Stall (out_valid & ~out_ready): all in_ready=0; out_data, out_src and ptr hold.
- Latency: input accept at edge k -> out_valid visible after edge k; data is never combinationally passed to the output.
- Fairness (mode=0): with all inputs continuously valid and out_ready=1, grant order is 0,1,…,N-1,0,…; no input waits more than N-1 accepts.
- Switching mode takes effect in the same cycle; ptr is not reset by a mode change.
- No X propagation: unselected in_data never reaches out_data.

Test Plan:
1. Reset: hold rst_n=0 with all in_valid=1 and out_ready=1 for 2 cycles -> out_valid=0, out_data=0, out_src=0, in_ready=0; after release, the first grant goes to input 0.
2. Round-robin fairness: N=8, W=32, in_valid=8'hFF, in_data[i]=32'hA0+i, out_ready=1 for 10 cycles -> out_src sequence 0,1,…,7,0,1 and out_data 32'hA0…32'hA7,32'hA0,32'hA1, out_valid continuously 1.
3. Sparse and wrap: ptr=6, in_valid=8'b0000_0101 -> grant input 0, then input 2, then input 0. With N=5, after granting index 4, ptr wraps to 0.
4. Backpressure: fill the output (out_src=3, out_data=32'hA3), then out_ready=0 for 3 cycles with in_valid=8'hFF -> in_ready=0, outputs frozen. Raising out_ready gives a drain and accept in the same edge, out_src=4.
5. Forced mode: mode=1, force_sel=5, in_valid=8'hFF -> only in_ready[5] high and out_src=5 every cycle. force_sel=5 with in_valid[5]=0 -> no grant, out_valid drops after drain. With N=5, force_sel=7 -> no grant.
6. Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0 and ptr=0 on the next cycle; the held entry is lost and never delivered.

Source files
------------

// File: rtl/mux_rr_nxw.sv
// N-input, W-bit registered selector with per-input valid/ready, round-robin or
// forced selection, and a single-entry output register.
module mux_rr_nxw #(
    parameter int N    = 8,
    parameter int W    = 32,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] force_sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_src,
    input  logic            out_ready
);

    logic            vld_p0;
    logic [W-1:0]    data_p0;
    logic [SELW-1:0] src_p0;
    logic [SELW-1:0] ptr;

    logic            space;
    logic            accept;
    logic            gnt_any;
    logic [SELW-1:0] gnt_idx;
    logic [N-1:0]    gnt;
    logic [W-1:0]    sel_data;
    logic [SELW:0]   cand;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
        logic [SELW-1:0] nxt;
        if (idx == SELW'(N - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + SELW'(1);
        end
        return nxt;
    endfunction

    // Grant search; the round-robin scan runs from the farthest offset down so
    // the candidate closest to ptr is the one left standing.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (force_sel == SELW'(i) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, ptr} + (SELW + 1)'(k);
                if (cand >= (SELW + 1)'(N)) begin
                    cand = cand - (SELW + 1)'(N);
                end
                if (in_valid[cand[SELW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[SELW-1:0];
                end
            end
        end
    end

    // One-hot grant and a data mux that only ever forwards the granted lane.
    always_comb begin
        gnt      = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && gnt_idx == SELW'(i)) begin
                gnt[i]   = 1'b1;
                sel_data = in_data[i*W +: W];
            end
        end
    end

    assign space    = ~vld_p0 | out_ready;
    assign accept   = gnt_any & space & rst_n;
    assign in_ready = gnt & {N{space & rst_n}};

    // Stage p0: output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            src_p0  <= '0;
            ptr     <= '0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= sel_data;
            src_p0  <= gnt_idx;
            ptr     <= wrap_inc(gnt_idx);
        end else if (out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_src   = src_p0;

endmodule
